// File: rtl/memory_access_stage.sv
// MEM pipeline stage: decodes loads/stores, drives a single-outstanding req/ack bus,
// and extends load data for WB. Define MEM_BUS_TIMEOUT_EN to abort hung accesses.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] AO,
  input  logic [31:0] rt,
  input  logic        exception_in,
  input  logic [31:0] EPC_in,
  input  logic [4:0]  ExcCode_in,
  input  logic        BD_in,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        stall,
  output logic [31:0] Inst_out,
  output logic [31:0] AO_out,
  output logic [31:0] DR,
  output logic        exception_out,
  output logic [31:0] EPC_out,
  output logic [4:0]  ExcCode_out,
  output logic        BD_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  state_t      state;
  logic [31:0] rdata_q;
  logic        is_load, is_store, is_word, is_half, is_byte, is_signed;
  logic        mem_op, misaligned, go, active, abort_done;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_word   = 1'b0;
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    case (Inst[31:26])
      6'h23: begin is_load  = 1'b1; is_word = 1'b1; end
      6'h21: begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      6'h25: begin is_load  = 1'b1; is_half = 1'b1; end
      6'h20: begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      6'h24: begin is_load  = 1'b1; is_byte = 1'b1; end
      6'h2B: begin is_store = 1'b1; is_word = 1'b1; end
      6'h29: begin is_store = 1'b1; is_half = 1'b1; end
      6'h28: begin is_store = 1'b1; is_byte = 1'b1; end
      default: ;
    endcase
  end

  assign mem_op     = is_load | is_store;
  assign misaligned = mem_op & ((is_word & (|AO[1:0])) | (is_half & AO[0]));
  assign go         = mem_op & ~exception_in & ~misaligned;
  // Gating with reset drops the request combinationally while reset is held.
  assign active     = go & reset & (state != DONE);
  assign bus_req    = active;
  assign stall      = active;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       aborted;

  // wait_cnt holds the number of completed WAIT cycles; the last allowed one aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rdata_q  <= '0;
      wait_cnt <= '0;
      aborted  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            state   <= DONE;
          end else begin
            state   <= WAIT;
          end
        end
        WAIT: if (bus_ack) begin
          rdata_q  <= bus_rdata;
          wait_cnt <= '0;
          state    <= DONE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          wait_cnt <= '0;
          aborted  <= 1'b1;
          state    <= DONE;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        DONE: begin
          aborted <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign abort_done = aborted & (state == DONE);
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            state   <= DONE;
          end else begin
            state   <= WAIT;
          end
        end
        WAIT: if (bus_ack) begin
          rdata_q <= bus_rdata;
          state   <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign abort_done = 1'b0;
`endif

  assign bus_we   = is_store;
  assign bus_addr = {AO[31:2], 2'b00};

  always_comb begin
    bus_be    = 4'b0000;
    bus_wdata = rt;
    if (is_word) begin
      bus_be = 4'b1111;
    end else if (is_half) begin
      bus_be    = AO[1] ? 4'b1100 : 4'b0011;
      bus_wdata = {2{rt[15:0]}};
    end else if (is_byte) begin
      bus_be    = 4'b0001 << AO[1:0];
      bus_wdata = {4{rt[7:0]}};
    end
  end

  assign lane_byte = rdata_q[{AO[1:0], 3'b000} +: 8];
  assign lane_half = AO[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    DR = '0;
    if (is_load & go & ~abort_done) begin
      if (is_word)
        DR = rdata_q;
      else if (is_half)
        DR = {{16{is_signed & lane_half[15]}}, lane_half};
      else
        DR = {{24{is_signed & lane_byte[7]}}, lane_byte};
    end
  end

  // An incoming exception always wins; otherwise this stage may raise its own.
  always_comb begin
    exception_out = exception_in;
    ExcCode_out   = ExcCode_in;
    Inst_out      = Inst;
    if (!exception_in) begin
      if (misaligned) begin
        exception_out = 1'b1;
        ExcCode_out   = is_store ? 5'd5 : 5'd4;
        Inst_out      = '0;
      end else if (abort_done) begin
        exception_out = 1'b1;
        ExcCode_out   = 5'd7;
        Inst_out      = '0;
      end
    end
  end

  assign AO_out  = AO;
  assign EPC_out = EPC_in;
  assign BD_out  = BD_in;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed vector table, hand-written
// reset/timeout sequences, and randomized accesses against a behavioural model.
module tb_memory_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst, AO, rt, EPC_in, bus_rdata;
  logic        exception_in, BD_in, bus_ack;
  logic [4:0]  ExcCode_in;
  logic        bus_req, bus_we, stall, exception_out, BD_out;
  logic [31:0] bus_addr, bus_wdata, Inst_out, AO_out, DR, EPC_out;
  logic [3:0]  bus_be;
  logic [4:0]  ExcCode_out;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .AO(AO), .rt(rt),
    .exception_in(exception_in), .EPC_in(EPC_in), .ExcCode_in(ExcCode_in), .BD_in(BD_in),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .stall(stall),
    .Inst_out(Inst_out), .AO_out(AO_out), .DR(DR), .exception_out(exception_out),
    .EPC_out(EPC_out), .ExcCode_out(ExcCode_out), .BD_out(BD_out)
  );

  typedef struct {
    int          stalls;
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr, wdata, dr, inst_out, ao, epc;
    logic        exc, bd;
    logic [4:0]  code;
  } exp_t;

  typedef struct {
    int          stalls;
    bit          timed_out, stable, req_end;
    logic [3:0]  be;
    logic        we, req;
    logic [31:0] addr, wdata, dr, inst_out, ao_out, epc_out;
    logic        exc, bd_out;
    logic [4:0]  code;
  } obs_t;

  typedef struct {
    logic [31:0] inst, ao, rt;
    logic        exc;
    logic [4:0]  code_in;
    logic [31:0] rdata;
    int          waits;
    exp_t        e;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Holds the instruction like the EX/MEM register would until stall drops.
  task automatic apply_stimulus(input logic [31:0] inst, ao, rt_v, input logic exc, input logic [4:0] code_in,
                                input logic [31:0] epc, input logic bd, input logic [31:0] rdata,
                                input int waits, output obs_t o);
    int cyc;
    @(negedge clk);
    Inst = inst; AO = ao; rt = rt_v; exception_in = exc; ExcCode_in = code_in;
    EPC_in = epc; BD_in = bd; bus_ack = 1'b0; bus_rdata = $urandom;
    o = '{stalls: 0, timed_out: 0, stable: 1, req_end: 0, be: 0, we: 0, req: 0, addr: 0, wdata: 0,
          dr: 0, inst_out: 0, ao_out: 0, epc_out: 0, exc: 0, bd_out: 0, code: 0};
    #1;
    cyc = 0;
    while (stall && cyc < 64) begin
      if (cyc == 0) begin
        o.req = bus_req; o.we = bus_we; o.addr = bus_addr; o.be = bus_be; o.wdata = bus_wdata;
        if (!bus_req) o.stable = 0;
      end else if (bus_req !== o.req || bus_we !== o.we || bus_addr !== o.addr ||
                   bus_be !== o.be || bus_wdata !== o.wdata) begin
        o.stable = 0;
      end
      o.stalls++;
      bus_ack   = (cyc == waits);
      bus_rdata = (cyc == waits) ? rdata : $urandom;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      cyc++;
    end
    o.timed_out = stall;
    o.req_end   = bus_req;
    o.dr = DR; o.inst_out = Inst_out; o.ao_out = AO_out; o.epc_out = EPC_out;
    o.exc = exception_out; o.bd_out = BD_out; o.code = ExcCode_out;
  endtask

  task automatic check_all(input string tag, input obs_t o, input exp_t e);
    check_output({tag, " stalls"}, 32'(o.stalls), 32'(e.stalls));
    check_output({tag, " stall_budget"}, 32'(o.timed_out), 32'd0);
    check_output({tag, " req_after_done"}, 32'(o.req_end), 32'd0);
    if (e.stalls > 0) begin
      check_output({tag, " be"}, 32'(o.be), 32'(e.be));
      check_output({tag, " we"}, 32'(o.we), 32'(e.we));
      check_output({tag, " addr"}, o.addr, e.addr);
      check_output({tag, " bus_stable"}, 32'(o.stable), 32'd1);
      if (e.we) check_output({tag, " wdata"}, o.wdata, e.wdata);
    end
    check_output({tag, " DR"}, o.dr, e.dr);
    check_output({tag, " exception_out"}, 32'(o.exc), 32'(e.exc));
    check_output({tag, " ExcCode_out"}, 32'(o.code), 32'(e.code));
    check_output({tag, " Inst_out"}, o.inst_out, e.inst_out);
    check_output({tag, " AO_out"}, o.ao_out, e.ao);
    check_output({tag, " EPC_out"}, o.epc_out, e.epc);
    check_output({tag, " BD_out"}, 32'(o.bd_out), 32'(e.bd));
  endtask

  // Behavioural reference: access size, lane offset and extension by plain arithmetic.
  function automatic exp_t model(input logic [31:0] inst, ao, rt_v, input logic exc, input logic [4:0] code_in,
                                 input logic [31:0] epc, input logic bd, input logic [31:0] rdata, input int waits);
    exp_t e;
    int size, off;
    bit ld, st, sgn;
    logic [31:0] mask, val;
    e = '{stalls: 0, be: 0, we: 0, addr: ao & 32'hFFFF_FFFC, wdata: 0, dr: 0, inst_out: inst,
          ao: ao, epc: epc, exc: exc, bd: bd, code: code_in};
    size = 0; ld = 0; st = 0; sgn = 0;
    case (inst[31:26])
      6'h23: begin size = 4; ld = 1; end
      6'h21: begin size = 2; ld = 1; sgn = 1; end
      6'h25: begin size = 2; ld = 1; end
      6'h20: begin size = 1; ld = 1; sgn = 1; end
      6'h24: begin size = 1; ld = 1; end
      6'h2B: begin size = 4; st = 1; end
      6'h29: begin size = 2; st = 1; end
      6'h28: begin size = 1; st = 1; end
      default: ;
    endcase
    if (exc || size == 0) return e;
    if ((ao % 32'(size)) != 0) begin
      e.exc = 1; e.code = st ? 5'd5 : 5'd4; e.inst_out = 0;
      return e;
    end
    off = int'(ao[1:0]);
    e.stalls = waits + 1;
    e.we = st;
    e.be = 4'(((1 << size) - 1) << off);
    if (st) e.wdata = (size == 4) ? rt_v : (size == 2) ? (rt_v & 32'hFFFF) * 32'h0001_0001
                                                       : (rt_v & 32'hFF) * 32'h0101_0101;
    if (ld) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
      val  = (rdata >> (8 * off)) & mask;
      if (sgn && val[8 * size - 1]) val = val | ~mask;
      e.dr = val;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] inst, ao, rt_v, input logic exc, input logic [4:0] code_in,
                               input logic [31:0] rdata, input int waits, input int e_stalls,
                               input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata, e_dr,
                               input logic e_exc, input logic [4:0] e_code, input logic [31:0] e_inst);
    vec_t v;
    v.inst = inst; v.ao = ao; v.rt = rt_v; v.exc = exc; v.code_in = code_in; v.rdata = rdata; v.waits = waits;
    v.e = '{stalls: e_stalls, be: e_be, we: e_we, addr: {ao[31:2], 2'b00}, wdata: e_wdata, dr: e_dr,
            inst_out: e_inst, ao: ao, epc: 32'h0, exc: e_exc, bd: 1'b0, code: e_code};
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    obs_t        o;
    exp_t        e;
    logic [5:0]  ops [10];
    logic [31:0] inst, ao, rv, rd, epc;
    logic        ex, bd;
    logic [4:0]  cin;
    int          w;

    ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28, 6'h00, 6'h0F};

    //                 inst          ao          rt           exc code  rdata        w  st be      we wdata         dr            exc code  inst_out
    vecs.push_back(mkv(32'h8C22_0000, 32'h100, 32'h0,        0, 5'd0, 32'hDEADBEEF, 0, 1, 4'b1111, 0, 32'h0,        32'hDEADBEEF, 0, 5'd0, 32'h8C22_0000));
    vecs.push_back(mkv(32'h8043_0000, 32'h103, 32'h0,        0, 5'd0, 32'h80FFFFFF, 3, 4, 4'b1000, 0, 32'h0,        32'hFFFFFF80, 0, 5'd0, 32'h8043_0000));
    vecs.push_back(mkv(32'h9043_0000, 32'h103, 32'h0,        0, 5'd0, 32'h80FFFFFF, 3, 4, 4'b1000, 0, 32'h0,        32'h00000080, 0, 5'd0, 32'h9043_0000));
    vecs.push_back(mkv(32'hA400_0000, 32'h202, 32'h1234ABCD, 0, 5'd0, 32'h0,        1, 2, 4'b1100, 1, 32'hABCDABCD, 32'h0,        0, 5'd0, 32'hA400_0000));
    vecs.push_back(mkv(32'h8C22_0000, 32'h101, 32'h0,        0, 5'd0, 32'h0,        0, 0, 4'b0000, 0, 32'h0,        32'h0,        1, 5'd4, 32'h0));
    vecs.push_back(mkv(32'hAC00_0000, 32'h102, 32'h5,        0, 5'd0, 32'h0,        0, 0, 4'b0000, 0, 32'h0,        32'h0,        1, 5'd5, 32'h0));
    vecs.push_back(mkv(32'h8400_0000, 32'h102, 32'h0,        0, 5'd0, 32'h80017FFF, 2, 3, 4'b1100, 0, 32'h0,        32'hFFFF8001, 0, 5'd0, 32'h8400_0000));
    vecs.push_back(mkv(32'h9400_0000, 32'h100, 32'h0,        0, 5'd0, 32'h8001F00D, 0, 1, 4'b0011, 0, 32'h0,        32'h0000F00D, 0, 5'd0, 32'h9400_0000));
    vecs.push_back(mkv(32'hA000_0000, 32'h301, 32'h000000A7, 0, 5'd0, 32'h0,        0, 1, 4'b0010, 1, 32'hA7A7A7A7, 32'h0,        0, 5'd0, 32'hA000_0000));
    vecs.push_back(mkv(32'h0085_1021, 32'h101, 32'h0,        0, 5'd0, 32'h0,        0, 0, 4'b0000, 0, 32'h0,        32'h0,        0, 5'd0, 32'h0085_1021));
    vecs.push_back(mkv(32'h8C22_0000, 32'h101, 32'h0,        1, 5'd10, 32'h0,       0, 0, 4'b0000, 0, 32'h0,        32'h0,        1, 5'd10, 32'h8C22_0000));
    vecs.push_back(mkv(32'h8400_0000, 32'h103, 32'h0,        0, 5'd0, 32'h0,        0, 0, 4'b0000, 0, 32'h0,        32'h0,        1, 5'd4, 32'h0));
    vecs.push_back(mkv(32'hAC00_0000, 32'h400, 32'hCAFEF00D, 0, 5'd0, 32'h0,        1, 2, 4'b1111, 1, 32'hCAFEF00D, 32'h0,        0, 5'd0, 32'hAC00_0000));

    reset = 1'b0; Inst = 32'h8C22_0000; AO = 32'h100; rt = '0; exception_in = 1'b0;
    ExcCode_in = '0; EPC_in = '0; BD_in = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset bus_req", 32'(bus_req), 32'd0);
    check_output("reset stall", 32'(stall), 32'd0);
    check_output("reset DR", DR, 32'h0);
    @(negedge clk);
    Inst = 32'h0; reset = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].inst, vecs[i].ao, vecs[i].rt, vecs[i].exc, vecs[i].code_in, 32'h0, 1'b0,
                     vecs[i].rdata, vecs[i].waits, o);
      check_all($sformatf("vec%0d", i), o, vecs[i].e);
    end

    // Reset pulsed during WAIT: request drops at once, then the held lw re-requests.
    @(negedge clk);
    Inst = 32'h8C22_0000; AO = 32'h100; exception_in = 1'b0; bus_ack = 1'b0; #1;
    check_output("rst_wait req_initial", 32'(bus_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678; #1;
    check_output("rst_wait bus_req", 32'(bus_req), 32'd0);
    check_output("rst_wait stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1; bus_ack = 1'b0; #1;
    check_output("rst_wait re_request", 32'(bus_req), 32'd1);
    check_output("rst_wait discarded_ack DR", DR, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'hFEED_C0DE;
    @(negedge clk);
    bus_ack = 1'b0; #1;
    check_output("rst_wait done stall", 32'(stall), 32'd0);
    check_output("rst_wait DR", DR, 32'hFEED_C0DE);

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack at all: the access aborts after TO WAIT cycles and reports DBE.
    apply_stimulus(32'h8C22_0000, 32'h180, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1000, o);
    e = '{stalls: TO + 1, be: 4'b1111, we: 0, addr: 32'h180, wdata: 0, dr: 0, inst_out: 0,
          ao: 32'h180, epc: 0, exc: 1, bd: 0, code: 5'd7};
    check_all("timeout", o, e);
    Inst = 32'h0; bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    @(negedge clk); #1;
    check_output("timeout stray_ack req", 32'(bus_req), 32'd0);
    check_output("timeout stray_ack exc", 32'(exception_out), 32'd0);
    bus_ack = 1'b0;
    apply_stimulus(32'h8C22_0000, 32'h180, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0BAD_F00D, 0, o);
    check_all("after_timeout", o, model(32'h8C22_0000, 32'h180, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0BAD_F00D, 0));
`endif

    for (int n = 0; n < 200; n++) begin
      inst = {ops[$urandom_range(0, 9)], 26'($urandom)};
      ao   = $urandom;
      rv   = $urandom;
      rd   = $urandom;
      epc  = $urandom;
      bd   = 1'($urandom);
      ex   = ($urandom_range(0, 9) == 0);
      cin  = 5'($urandom);
      w    = $urandom_range(0, 3);
      apply_stimulus(inst, ao, rv, ex, cin, epc, bd, rd, w, o);
      check_all($sformatf("rand%0d", n), o, model(inst, ao, rv, ex, cin, epc, bd, rd, w));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
